// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
// Shared constants for the single-cycle MIPS R-type lab CPU.
package mips_pkg;

    localparam int unsigned ROM_DEPTH = 64;
    localparam int unsigned ROM_AW    = $clog2(ROM_DEPTH);
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_AW    = $clog2(REG_COUNT);
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned PC_W      = 8;

    localparam logic [OP_W-1:0] ALU_AND = 3'b000;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [OP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b110;
    localparam logic [OP_W-1:0] ALU_SLT = 3'b111;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;

endpackage

// File: rtl/mips_alu.sv
`timescale 1ns/1ps
// 32-bit ALU: and/or/add/sub/signed set-less-than, wrap-around arithmetic.
module mips_alu
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result
);

    // Select the operation result; unused encodings fall back to add.
    always_comb begin
        result = a + b;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = DATA_W'(($signed(a) < $signed(b)) ? 1'b1 : 1'b0);
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/experiment.sv
`timescale 1ns/1ps
// Single-cycle MIPS R-type CPU with fixed instruction ROM and LED debug view.
module experiment
    import mips_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [2:0]        SEL,
    output logic [7:0]        LED,
    output logic [DATA_W-1:0] dbg_inst,
    output logic [DATA_W-1:0] dbg_a,
    output logic [DATA_W-1:0] dbg_b,
    output logic [OP_W-1:0]   dbg_op,
    output logic              dbg_we,
    output logic [DATA_W-1:0] alu_output
);

    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [ROM_AW-1:0] rom_idx;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              unused_shamt;

    assign rom_idx = pc[PC_W-1:2];
    assign opcode  = dbg_inst[31:26];
    assign rs      = dbg_inst[25:21];
    assign rt      = dbg_inst[20:16];
    assign rd      = dbg_inst[15:11];
    assign funct   = dbg_inst[5:0];
    assign unused_shamt = ^dbg_inst[10:6];

    // Fixed program ROM; everything past word 4 is a nop.
    always_comb begin
        dbg_inst = '0;
        case (rom_idx)
            6'd0:    dbg_inst = 32'h0022_1820;
            6'd1:    dbg_inst = 32'h0041_2022;
            6'd2:    dbg_inst = 32'h00C7_2824;
            6'd3:    dbg_inst = 32'h0022_4025;
            6'd4:    dbg_inst = 32'h0022_482A;
            default: dbg_inst = '0;
        endcase
    end

    // Decode funct into ALU op and write enable; anything unknown is a nop.
    always_comb begin
        dbg_op = ALU_ADD;
        dbg_we = 1'b0;
        if (opcode == OPCODE_RTYPE) begin
            case (funct)
                FUNCT_AND: begin dbg_op = ALU_AND; dbg_we = 1'b1; end
                FUNCT_OR:  begin dbg_op = ALU_OR;  dbg_we = 1'b1; end
                FUNCT_ADD: begin dbg_op = ALU_ADD; dbg_we = 1'b1; end
                FUNCT_SUB: begin dbg_op = ALU_SUB; dbg_we = 1'b1; end
                FUNCT_SLT: begin dbg_op = ALU_SLT; dbg_we = 1'b1; end
                default:   begin dbg_op = ALU_ADD; dbg_we = 1'b0; end
            endcase
        end
    end

    // Asynchronous register reads; r0 is hard-wired to zero.
    always_comb begin
        dbg_a = (rs == '0) ? '0 : regs[rs];
        dbg_b = (rt == '0) ? '0 : regs[rt];
    end

    mips_alu u_alu (
        .a      (dbg_a),
        .b      (dbg_b),
        .op     (dbg_op),
        .result (alu_output)
    );

    // PC advance and register write-back share one edge; reset seeds r[i]=i.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= '0;
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else begin
            if (dbg_we && (rd != '0)) begin
                regs[rd] <= alu_output;
            end
            pc <= pc + PC_W'(4);
        end
    end

    // LED byte selection over ALU result, PC, instruction and decode state.
    always_comb begin
        LED = '0;
        case (SEL)
            3'd0: LED = alu_output[7:0];
            3'd1: LED = alu_output[15:8];
            3'd2: LED = alu_output[23:16];
            3'd3: LED = alu_output[31:24];
            3'd4: LED = pc;
            3'd5: LED = dbg_inst[7:0];
            3'd6: LED = {dbg_we, 4'b0000, dbg_op};
            3'd7: LED = dbg_a[7:0];
            default: LED = '0;
        endcase
    end

endmodule

// File: tb/tb_experiment.sv
`timescale 1ns/1ps
// Self-checking bench for the single-cycle R-type CPU.
module tb_experiment;

    logic        CLK;
    logic        RST;
    logic [2:0]  SEL;
    logic [7:0]  LED;
    logic [31:0] dbg_inst;
    logic [31:0] dbg_a;
    logic [31:0] dbg_b;
    logic [2:0]  dbg_op;
    logic        dbg_we;
    logic [31:0] alu_output;

    int n_vec;
    int n_bad;

    // Bench-side architectural model: program, register file, PC.
    logic [31:0] prog  [64];
    logic [31:0] regs_m [32];
    logic [7:0]  pc_m;

    experiment dut (
        .CLK        (CLK),
        .RST        (RST),
        .SEL        (SEL),
        .LED        (LED),
        .dbg_inst   (dbg_inst),
        .dbg_a      (dbg_a),
        .dbg_b      (dbg_b),
        .dbg_op     (dbg_op),
        .dbg_we     (dbg_we),
        .alu_output (alu_output)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pc_m = 8'h00;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'(i);
    endtask

    // Architectural meaning of the current instruction.
    task automatic model_eval(output logic [31:0] inst, output logic [31:0] a,
                              output logic [31:0] b, output logic [31:0] res,
                              output logic [2:0] op, output logic we, output logic [4:0] rd);
        logic [5:0] fn;
        inst = prog[pc_m >> 2];
        a    = regs_m[inst[25:21]];
        b    = regs_m[inst[20:16]];
        rd   = inst[15:11];
        fn   = inst[5:0];
        res  = a + b;
        op   = 3'b010;
        we   = 1'b0;
        if (inst[31:26] == 6'd0) begin
            case (fn)
                6'h20: begin res = a + b; op = 3'b010; we = 1'b1; end
                6'h22: begin res = a - b; op = 3'b110; we = 1'b1; end
                6'h24: begin res = a & b; op = 3'b000; we = 1'b1; end
                6'h25: begin res = a | b; op = 3'b001; we = 1'b1; end
                6'h2A: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; op = 3'b111; we = 1'b1; end
                default: ;
            endcase
        end
    endtask

    // Compare every DUT output (all LED selects) against the model.
    task automatic check_model();
        logic [31:0] inst, a, b, res;
        logic [2:0]  op;
        logic        we;
        logic [4:0]  rd;
        logic [7:0]  led_e;
        model_eval(inst, a, b, res, op, we, rd);
        chk("inst", dbg_inst, inst);
        chk("a", dbg_a, a);
        chk("b", dbg_b, b);
        chk("alu", alu_output, res);
        chk("op", 32'(dbg_op), 32'(op));
        chk("we", 32'(dbg_we), 32'(we));
        for (int s = 0; s < 8; s++) begin
            SEL = 3'(s);
            #1;
            case (s)
                0: led_e = res[7:0];
                1: led_e = res[15:8];
                2: led_e = res[23:16];
                3: led_e = res[31:24];
                4: led_e = pc_m;
                5: led_e = inst[7:0];
                6: led_e = {we, 4'b0000, op};
                default: led_e = a[7:0];
            endcase
            chk($sformatf("led_sel%0d", s), 32'(LED), 32'(led_e));
        end
    endtask

    // Advance the model, then apply one full clock period.
    task automatic tick();
        logic [31:0] inst, a, b, res;
        logic [2:0]  op;
        logic        we;
        logic [4:0]  rd;
        model_eval(inst, a, b, res, op, we, rd);
        if (we && rd != 5'd0) regs_m[rd] = res;
        pc_m = pc_m + 8'd4;
        CLK = 1'b1;
        #5;
        CLK = 1'b0;
        #5;
    endtask

    task automatic lit_led(input string name, input logic [2:0] s, input logic [7:0] exp);
        SEL = s;
        #1;
        chk(name, 32'(LED), 32'(exp));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0] = 32'h00221820;
        prog[1] = 32'h00412022;
        prog[2] = 32'h00C72824;
        prog[3] = 32'h00224025;
        prog[4] = 32'h0022482A;
        model_reset();

        CLK = 1'b0;
        SEL = 3'd0;
        RST = 1'b1;
        #5;
        RST = 1'b0;
        #1;

        // Reset state, no clock yet.
        chk("rst_inst", dbg_inst, 32'h00221820);
        chk("rst_a", dbg_a, 32'd1);
        chk("rst_b", dbg_b, 32'd2);
        chk("rst_op", 32'(dbg_op), 32'h2);
        chk("rst_we", 32'(dbg_we), 32'd1);
        chk("rst_alu", alu_output, 32'd3);
        lit_led("rst_led0", 3'd0, 8'h03);
        check_model();

        // Edge 1: add executed, sub fetched.
        tick();
        chk("e1_inst", dbg_inst, 32'h00412022);
        chk("e1_a", dbg_a, 32'd2);
        chk("e1_b", dbg_b, 32'd1);
        chk("e1_op", 32'(dbg_op), 32'h6);
        chk("e1_alu", alu_output, 32'd1);
        lit_led("e1_led4", 3'd4, 8'h04);
        check_model();

        // Edge 2: and fetched.
        tick();
        chk("e2_inst", dbg_inst, 32'h00C72824);
        chk("e2_a", dbg_a, 32'd6);
        chk("e2_b", dbg_b, 32'd7);
        chk("e2_op", 32'(dbg_op), 32'h0);
        chk("e2_alu", alu_output, 32'd6);
        check_model();

        // Edges 3 and 4: or, then slt.
        tick();
        chk("e3_op", 32'(dbg_op), 32'h1);
        chk("e3_alu", alu_output, 32'd3);
        check_model();
        tick();
        chk("e4_op", 32'(dbg_op), 32'h7);
        chk("e4_alu", alu_output, 32'd1);
        check_model();

        // Edge 5: slt writes r9, PC lands on first nop.
        tick();
        chk("e5_pc", 32'(dut.pc), 32'h14);
        chk("e5_r9", dut.regs[9], 32'd1);
        chk("e5_r3", dut.regs[3], 32'd3);
        chk("e5_r4", dut.regs[4], 32'd1);
        chk("e5_r5", dut.regs[5], 32'd6);
        chk("e5_r8", dut.regs[8], 32'd3);
        chk("nop_we", 32'(dbg_we), 32'd0);
        lit_led("nop_led6", 3'd6, 8'h02);
        check_model();

        // Run through the nops, wrap PC, and replay the program once.
        for (int k = 0; k < 64; k++) begin
            tick();
            check_model();
        end
        for (int i = 0; i < 32; i++) chk($sformatf("wrap_r%0d", i), dut.regs[i], regs_m[i]);

        // Fresh start, stop at PC=0x0C, then reset with no clock edge.
        RST = 1'b1;
        #2;
        RST = 1'b0;
        #3;
        model_reset();
        tick();
        tick();
        tick();
        lit_led("mid_led4", 3'd4, 8'h0C);
        chk("mid_r4", dut.regs[4], 32'd1);
        RST = 1'b1;
        #1;
        model_reset();
        lit_led("mrst_led4_lo", 3'd4, 8'h00);
        chk("mrst_r3", dut.regs[3], 32'd3);
        chk("mrst_r4", dut.regs[4], 32'd4);
        chk("mrst_inst", dbg_inst, 32'h00221820);
        check_model();
        CLK = 1'b1;
        #2;
        lit_led("mrst_led4_hi", 3'd4, 8'h00);
        chk("mrst_r5_hi", dut.regs[5], 32'd5);
        check_model();
        CLK = 1'b0;
        #2;
        RST = 1'b0;
        #2;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
